// File: rtl/nibble_seq_pkg.sv
// ---------------------------------------------------------------------------
// nibble_seq_pkg
//
// Shared definitions for the nibble pair sequencer:
//   seq_state_e : sequencer FSM states (IDLE, RUN, DRAIN, DONE)
//   W           : default operand width
//   DEPTH       : default FIFO depth (power of 2, >= 2)
//   CNT_W       : default pair counter width
//   LFSR_TAPS   : tap mask for the 4-bit Fibonacci LFSR x^4+x^3+1
//
// The sequencer's optional LFSR b-generator is enabled with the
// NIBBLE_PAIR_SEQ_LFSR_EN macro.
// ---------------------------------------------------------------------------
package nibble_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  // Bits 3 and 2 feed the XOR, giving the maximal-length x^4+x^3+1 sequence.
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

endpackage

// File: rtl/nibble_pair_seq_fifo.sv
// ---------------------------------------------------------------------------
// nibble_fifo
//
// Synchronous FIFO used by nibble_pair_seq to buffer generated pairs.
// All outputs (dout, full, empty) are registered; reset empties the FIFO
// and clears dout so the consumer never sees X.
//
// Parameters:
//   DW    : data width (2*W for a packed {a, b} pair)
//   DEPTH : number of entries, power of 2 and at least 2
//
// Ports:
//   clk   in  1   : rising-edge clock
//   rst   in  1   : synchronous active-high reset
//   push  in  1   : write din (ignored while full)
//   pop   in  1   : drop the head entry (ignored while empty)
//   din   in  DW  : write data
//   dout  out DW  : head entry, registered
//   full  out 1   : registered full flag
//   empty out 1   : registered empty flag
// ---------------------------------------------------------------------------
module nibble_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [DW-1:0] head_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Occupancy after this edge, used to register the full/empty flags.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // The head register must hold whatever entry sits at the read pointer
  // after this edge. A push lands directly in the head when the FIFO is
  // empty, or when the only stored entry is being popped on the same edge.
  always_comb begin
    head_nxt = dout;
    if (do_push && ((count == CNT_ZERO) || (do_pop && (count == CNT_ONE)))) begin
      head_nxt = din;
    end else if (do_pop && (count > CNT_ONE)) begin
      head_nxt = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_nxt;
      dout  <= head_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == CNT_ZERO);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/nibble_pair_seq.sv
// ---------------------------------------------------------------------------
// nibble_pair_seq
//
// Clocked stimulus source producing num_pairs operand pairs (a, b) and
// delivering them through a small FIFO with a valid/ready handshake.
//   a_k = seed_a + k (mod 2^W)
//   b_k = seed_b - k (mod 2^W), or a 4-bit Fibonacci LFSR (x^4+x^3+1)
//         seeded from seed_b when NIBBLE_PAIR_SEQ_LFSR_EN is defined
//         (LFSR build requires W = 4; a zero seed is replaced by 4'b0001).
//
// Parameters:
//   W     : operand width
//   DEPTH : FIFO depth, power of 2 and at least 2
//   CNT_W : pair counter width
//
// Ports:
//   clk       in  1     : rising-edge clock
//   rst       in  1     : synchronous active-high reset
//   start     in  1     : begin a run (sampled only in IDLE)
//   num_pairs in  CNT_W : pairs to generate, latched on accepted start
//   seed_a    in  W     : first a value, latched on accepted start
//   seed_b    in  W     : first b value / LFSR seed, latched on start
//   busy      out 1     : run in progress (RUN or DRAIN)
//   done      out 1     : one-cycle pulse after the last pair is popped
//   out_valid out 1     : FIFO holds a pair
//   out_ready in  1     : consumer accepts the head pair
//   out_a     out W     : a value of the head pair
//   out_b     out W     : b value of the head pair
// ---------------------------------------------------------------------------
module nibble_pair_seq #(
  parameter int W     = nibble_seq_pkg::W,
  parameter int DEPTH = nibble_seq_pkg::DEPTH,
  parameter int CNT_W = nibble_seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [W-1:0]     seed_a,
  input  logic [W-1:0]     seed_b,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b
);

  import nibble_seq_pkg::*;

  localparam logic [CNT_W-1:0] K_ONE = CNT_W'(1);

  seq_state_e     state;
  seq_state_e     state_nxt;

  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] num_q;
  logic [W-1:0]     a_cur;
  logic [W-1:0]     b_cur;
  logic [W-1:0]     b_step;
  logic [W-1:0]     b_seed;

  logic             push;
  logic             pop_fire;
  logic             last_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2*W-1:0]   fifo_dout;

  assign out_valid = !fifo_empty;
  assign out_a     = fifo_dout[2*W-1:W];
  assign out_b     = fifo_dout[W-1:0];
  assign pop_fire  = out_valid && out_ready;

  // Push is gated by the registered full flag only, so a pop on a full
  // FIFO frees a slot that is refilled on the following edge.
  assign push = (state == RUN) && !fifo_full && (k < num_q);

  // The final pop is recognised on the edge it happens, so DONE follows
  // it by exactly one cycle rather than waiting for the empty flag.
  assign last_pop = pop_fire && (pop_cnt == (num_q - K_ONE));

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
  // Shift toward the MSB and feed the XOR of the tapped bits into bit 0.
  assign b_step = {b_cur[W-2:0], ^(b_cur & W'(LFSR_TAPS))};
  // An all-zero seed would lock the LFSR up.
  assign b_seed = (seed_b == '0) ? W'(1) : seed_b;
`else
  assign b_step = b_cur - 1'b1;
  assign b_seed = seed_b;
`endif

  // Next-state logic. RUN hands over to DRAIN on the edge that pushes the
  // final pair (or immediately when nothing is left to push).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if ((k >= num_q) || (push && ((k + K_ONE) == num_q))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || last_pop) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run parameters, pair counters and the running a/b generator values.
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      pop_cnt <= '0;
      num_q   <= '0;
      a_cur   <= '0;
      b_cur   <= '0;
    end else if ((state == IDLE) && start) begin
      k       <= '0;
      pop_cnt <= '0;
      num_q   <= num_pairs;
      a_cur   <= seed_a;
      b_cur   <= b_seed;
    end else begin
      if (push) begin
        k     <= k + K_ONE;
        a_cur <= a_cur + 1'b1;
        b_cur <= b_step;
      end
      if (pop_fire) begin
        pop_cnt <= pop_cnt + K_ONE;
      end
    end
  end

  nibble_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_fire),
    .din   ({a_cur, b_cur}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_nibble_pair_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_pair_seq
//
// Directed self-checking bench for nibble_pair_seq. Inputs are driven and
// outputs sampled on the falling clock edge. Expected pair values are
// hand-computed tables; the b column switches with NIBBLE_PAIR_SEQ_LFSR_EN.
// ---------------------------------------------------------------------------
module tb_nibble_pair_seq;

  import nibble_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_pairs;
  logic [3:0] seed_a;
  logic [3:0] seed_b;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_a;
  logic [3:0] out_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] exp_a [16];
  logic [3:0] exp_b [16];

  always #5 clk = ~clk;

  nibble_pair_seq #(
    .W     (4),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_pairs (num_pairs),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the
  // rising edge that accepts start.
  task automatic applyStimulus(input int n, input logic [3:0] sa, input logic [3:0] sb);
    num_pairs = 8'(n);
    seed_a    = sa;
    seed_b    = sb;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Pops n pairs against the expectation tables, with a cycle budget.
  task automatic collectPairs(input string tag, input int n);
    int idx;
    int cyc;
    int first_cyc;
    int last_cyc;
    int done_early;
    idx = 0; cyc = 0; first_cyc = 0; last_cyc = 0; done_early = 0;
    while ((idx < n) && (cyc < 200)) begin
      if (done) done_early = 1;
      if (out_valid && out_ready) begin
        checkOutput({tag, "_a"}, 32'(out_a), 32'(exp_a[idx]));
        checkOutput({tag, "_b"}, 32'(out_b), 32'(exp_b[idx]));
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_npop"}, 32'(idx), 32'(n));
    checkOutput({tag, "_thru"}, 32'(last_cyc - first_cyc), 32'(n - 1));
    checkOutput({tag, "_done_early"}, 32'(done_early), 32'd0);
  endtask

  // Expects the done pulse in the cycle right after the last pop.
  task automatic checkDone(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; num_pairs = '0; seed_a = '0; seed_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",  32'(busy),      32'd0);
    checkOutput("rst_done",  32'(done),      32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_a",     32'(out_a),     32'd0);
    checkOutput("rst_b",     32'(out_b),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run: (3,7), (4,6), (5,5)
    exp_a[0] = 4'h3; exp_a[1] = 4'h4; exp_a[2] = 4'h5;
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h7; exp_b[1] = 4'hF; exp_b[2] = 4'hE;
`else
    exp_b[0] = 4'h7; exp_b[1] = 4'h6; exp_b[2] = 4'h5;
`endif
    applyStimulus(3, 4'h3, 4'h7);
    checkOutput("basic_busy",   32'(busy),      32'd1);
    checkOutput("basic_lat0",   32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("basic_lat1",   32'(out_valid), 32'd1);
    collectPairs("basic", 3);
    checkDone("basic");

    // Wrap: a = E, F, 0
    exp_a[0] = 4'hE; exp_a[1] = 4'hF; exp_a[2] = 4'h0;
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h1; exp_b[1] = 4'h2; exp_b[2] = 4'h4;
`else
    exp_b[0] = 4'h1; exp_b[1] = 4'h0; exp_b[2] = 4'hF;
`endif
    applyStimulus(3, 4'hE, 4'h1);
    collectPairs("wrap", 3);
    checkDone("wrap");

    // Backpressure: six pairs, consumer stalled for ten cycles
    for (int i = 0; i < 6; i++) exp_a[i] = 4'(i);
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h9; exp_b[1] = 4'h3; exp_b[2] = 4'h6;
    exp_b[3] = 4'hD; exp_b[4] = 4'hA; exp_b[5] = 4'h5;
`else
    exp_b[0] = 4'h9; exp_b[1] = 4'h8; exp_b[2] = 4'h7;
    exp_b[3] = 4'h6; exp_b[4] = 4'h5; exp_b[5] = 4'h4;
`endif
    out_ready = 1'b0;
    applyStimulus(6, 4'h0, 4'h9);
    repeat (5) @(negedge clk);
    checkOutput("bp_full",   32'(dut.fifo_full), 32'd1);
    checkOutput("bp_valid",  32'(out_valid),     32'd1);
    checkOutput("bp_a",      32'(out_a),         32'h0);
    checkOutput("bp_b",      32'(out_b),         32'h9);
    repeat (4) @(negedge clk);
    checkOutput("bp_hold_a", 32'(out_a),         32'h0);
    checkOutput("bp_hold_b", 32'(out_b),         32'h9);
    checkOutput("bp_busy",   32'(busy),          32'd1);
    out_ready = 1'b1;
    collectPairs("bp", 6);
    checkDone("bp");

    // Zero length: done 3 cycles after start, never valid
    applyStimulus(0, 4'h5, 4'h5);
    checkOutput("zero_valid0", 32'(out_valid), 32'd0);
    checkOutput("zero_done0",  32'(done),      32'd0);
    @(negedge clk);
    checkOutput("zero_valid1", 32'(out_valid), 32'd0);
    checkOutput("zero_done1",  32'(done),      32'd0);
    @(negedge clk);
    checkOutput("zero_valid2", 32'(out_valid), 32'd0);
    checkDone("zero");

    // Reset after two of five pairs
    exp_a[0] = 4'hA; exp_a[1] = 4'hB;
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h2; exp_b[1] = 4'h4;
`else
    exp_b[0] = 4'h2; exp_b[1] = 4'h1;
`endif
    applyStimulus(5, 4'hA, 4'h2);
    collectPairs("midrst", 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy",  32'(busy),      32'd0);
    checkOutput("midrst_done",  32'(done),      32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_a",     32'(out_a),     32'd0);
    checkOutput("midrst_b",     32'(out_b),     32'd0);
    checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid) done_seen = 1;
    end
    checkOutput("midrst_quiet", 32'(done_seen), 32'd0);

    exp_a[0] = 4'h8; exp_a[1] = 4'h9;
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h8; exp_b[1] = 4'h1;
`else
    exp_b[0] = 4'h8; exp_b[1] = 4'h7;
`endif
    applyStimulus(2, 4'h8, 4'h8);
    collectPairs("restart", 2);
    checkDone("restart");

    // Zero seed_b, plus start pulses while busy and during DONE
    for (int i = 0; i < 5; i++) exp_a[i] = 4'(i + 1);
`ifdef NIBBLE_PAIR_SEQ_LFSR_EN
    exp_b[0] = 4'h1; exp_b[1] = 4'h2; exp_b[2] = 4'h4;
    exp_b[3] = 4'h9; exp_b[4] = 4'h3;
`else
    exp_b[0] = 4'h0; exp_b[1] = 4'hF; exp_b[2] = 4'hE;
    exp_b[3] = 4'hD; exp_b[4] = 4'hC;
`endif
    applyStimulus(5, 4'h1, 4'h0);
    applyStimulus(9, 4'hF, 4'hF);
    collectPairs("lfsr", 5);
    checkOutput("lfsr_done",  32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("donestart_busy", 32'(busy), 32'd0);
    checkOutput("donestart_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("donestart_idle", 32'(busy), 32'd0);
    checkOutput("donestart_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
